// File: rtl/fifo_wr_arbiter_if.sv
// Signal bundle between the write-port arbiter, its requesters and the FIFO
// write port. The arbiter connects through the master modport; the
// environment (requesters, FIFO, status observers) uses the slave modport.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data_in;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts for one packet (req_last) or MAX_BURST beats, whichever
// comes first, then the search pointer moves past the released requester.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | arbitration cycle; pick first valid requester from rr_ptr
//   ST_GRANT | granted requester owns the write port until release
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk_wr,
    input  logic               i_wr_reset_n,
    fifo_wr_arbiter_if.master  bus
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_rr_ptr_nxt;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   w_grant_id_nxt;
    logic [7:0]        r_beat_cnt;
    logic [7:0]        w_beat_cnt_nxt;
    logic              r_busy;
    logic              w_busy_nxt;

    logic              w_any_req;
    logic [ID_W-1:0]   w_sel;
    logic              w_g_valid;
    logic              w_g_last;
    logic [DATA_W-1:0] w_g_data;
    logic              w_xfer;
    logic              w_release;

    // Round-robin search: first valid requester at or after rr_ptr (wrapping).
    always_comb begin : p_rr_search
        int idx;
        w_any_req = 1'b0;
        w_sel     = r_rr_ptr;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_any_req && bus.req_valid[idx]) begin
                w_any_req = 1'b1;
                w_sel     = ID_W'(idx);
            end
        end
    end

    // Select the granted requester's valid/last/data.
    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        w_g_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == r_grant_id) begin
                w_g_valid = bus.req_valid[k];
                w_g_last  = bus.req_last[k];
                w_g_data  = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_xfer    = (r_state == ST_GRANT) && w_g_valid && !bus.fifo_full;
    assign w_release = w_xfer && (w_g_last || (r_beat_cnt == 8'(MAX_BURST - 1)));

    // Next-state logic: grant on any request in IDLE, release on last beat or burst limit.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        w_beat_cnt_nxt = r_beat_cnt;
        w_busy_nxt     = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt    = ST_GRANT;
                    w_grant_id_nxt = w_sel;
                    w_beat_cnt_nxt = 8'd0;
                    w_busy_nxt     = 1'b1;
                end
            end
            ST_GRANT: begin
                if (w_xfer) begin
                    w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                end
                if (w_release) begin
                    w_state_nxt  = ST_IDLE;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                      : r_grant_id + ID_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge i_clk_wr or negedge i_wr_reset_n) begin
        if (!i_wr_reset_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // One-hot ready to the granted requester while the FIFO can take a beat.
    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if ((r_state == ST_GRANT) && !bus.fifo_full && (ID_W'(k) == r_grant_id)) begin
                bus.req_ready[k] = 1'b1;
            end
        end
    end

    assign bus.fifo_wr_en   = w_xfer;
    assign bus.fifo_data_in = (r_state == ST_GRANT) ? w_g_data : '0;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = r_busy;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter for the write side of gray_fifo_cdc. It lives entirely in the write clock domain. It shares the FIFO's single write port (wr_en/data_in, back-pressured by full) between NUM_REQ requesters using valid/ready handshakes. A grant is held for one packet, ending on req_last or after MAX_BURST beats, so no requester can starve the others.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, data width; matches FIFO data_in
MAX_BURST, 4, max beats per grant before forced rotation (1..255)
ID_W, $clog2(NUM_REQ) (min 1), width of grant_id

Ports:
clk_wr  input  1  write-domain clock, rising edge
wr_reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_W  packed data; requester k owns bits [k*DATA_W +: DATA_W]
req_last  input  NUM_REQ  per-requester last beat of packet
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
fifo_full  input  1  FIFO full flag (write domain)
fifo_wr_en  output  1  to FIFO wr_en
fifo_data_in  output  DATA_W  to FIFO data_in
grant_id  output  ID_W  index of current/last granted requester
busy  output  1  high while a grant is active

Behaviour:
- Clock and reset: one clock, clk_wr. Reset wr_reset_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0.
  - Combinational outputs req_ready=0, fifo_wr_en=0, fifo_data_in=0.
  - Asserting reset mid-packet drops all outputs immediately. Any beat not yet clocked is not written.
- FSM with two states, IDLE and GRANT.
  - IDLE: if any req_valid is high, select the first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that selection: grant_id<=k, beat_cnt<=0, busy<=1, go to GRANT. If no request, stay in IDLE.
  - GRANT: transfer = req_valid[g] & !fifo_full, where g=grant_id. On each transfer, beat_cnt<=beat_cnt+1.
  - Release when transfer & (req_last[g] | beat_cnt==MAX_BURST-1): go to IDLE, rr_ptr<=(g+1) mod NUM_REQ, busy<=0.
  - Otherwise hold GRANT. The grant is held while req_valid[g] is low; no timeout.
- Datapath, combinational and zero latency:
  - req_ready[g] = (state==GRANT) & !fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = (state==GRANT) & req_valid[g] & !fifo_full. It is never high while fifo_full=1, so no write is ever dropped or overwritten.
  - fifo_data_in = req_data[g] in GRANT, 0 in IDLE.
- Timing: one dead arbitration cycle in IDLE between consecutive grants. A request seen in cycle n gives its first possible beat in cycle n+1.
- fifo_full rising mid-packet stalls the granted requester. The grant is held, with no rotation, until full deasserts.
- A forced release at MAX_BURST does not consume req_last. The requester continues its packet at its next grant.
- beat_cnt width is 8 bits and resets to 0 on every new grant.
- rr_ptr is updated only on release, never in IDLE.
- The arbiter does not track FIFO occupancy; it relies only on fifo_full.

Test Plan:
- Single packet: req_valid[1]=1 with data 0xA1,0xA2,0xA3, req_last on 0xA3, fifo_full=0 -> grant_id=1 one cycle later. fifo_wr_en high for exactly 3 cycles carrying A1,A2,A3. busy drops the cycle after A3. rr_ptr=2.
- Contention after reset (rr_ptr=0): req 0 and 2 valid, each a 2-beat packet -> FIFO order is 0's two beats, one IDLE cycle, then 2's two beats. grant_id sequence 0, 2.
- Fairness: all 4 requesters continuously valid, 1-beat packets -> grant_id rotates 0,1,2,3,0,1. One write every 2 cycles.
- Burst cut: MAX_BURST=4, req 0 sends a 6-beat packet while req 3 is also valid -> 4 beats from 0, then 1 packet from 3, then the remaining 2 beats from 0, with req_last on the 6th.
- Back-pressure: force fifo_full=1 for 5 cycles mid-packet -> fifo_wr_en=0 and req_ready=0 throughout, grant_id unchanged, no beat lost or duplicated. The packet resumes on the cycle full drops.
- Reset mid-operation: pull wr_reset_n low after 2 of 4 beats -> fifo_wr_en, req_ready and busy go 0 asynchronously. After release, grant_id=0, rr_ptr=0, and the next grant starts from the lowest valid requester.
